// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in clk cycles.
// Latency: res_valid rises 4 clk after the pwm_in rise that closes a measured period.
// Backpressure: one-deep result holding register; a capture arriving while it is full and not accepted is discarded and pulses dropped.
module pwm_capture #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         pwm_in,
  input  logic         res_ready,
  output logic         res_valid,
  output logic [W-1:0] res_high,
  output logic [W-1:0] res_period,
  output logic         res_ovf,
  output logic         dropped
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t       r_state;
  logic         r_sync1;
  logic         r_sync2;
  logic         r_sync3;
  logic [W-1:0] r_high_cnt;
  logic [W-1:0] r_per_cnt;
  logic         r_ovf;
  logic         r_valid;
  logic [W-1:0] r_res_high;
  logic [W-1:0] r_res_per;
  logic         r_res_ovf;
  logic         r_dropped;

  logic         w_rise;
  logic         w_fall;
  logic         w_cap;
  logic         w_high_sat;
  logic         w_per_sat;
  logic [W-1:0] w_cap_high;

  assign w_rise     = r_sync2 & ~r_sync3;
  assign w_fall     = ~r_sync2 & r_sync3;
  // A rise closes a period only once a measurement is running (HIGH or LOW).
  assign w_cap      = enable & w_rise & ((r_state == HIGH) || (r_state == LOW));
  assign w_high_sat = (r_high_cnt == CNT_MAX);
  assign w_per_sat  = (r_per_cnt == CNT_MAX);
  // A rise seen while still HIGH means the fall was missed: the whole period counts as high.
  assign w_cap_high = (r_state == HIGH) ? r_per_cnt : r_high_cnt;

  // Two-flop synchronizer followed by the edge-detect history flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Measurement FSM with saturating high/period counters; both counters start at 1 on a rise
  // so the value held at the next rise equals the cycle distance between the two detected edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_high_cnt <= '0;
      r_per_cnt  <= '0;
      r_ovf      <= 1'b0;
    end else if (!enable) begin
      r_state    <= IDLE;
      r_high_cnt <= '0;
      r_per_cnt  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= ARM;
          r_high_cnt <= '0;
          r_per_cnt  <= '0;
          r_ovf      <= 1'b0;
        end
        ARM: begin
          if (w_rise) begin
            r_state    <= HIGH;
            r_high_cnt <= CNT_ONE;
            r_per_cnt  <= CNT_ONE;
            r_ovf      <= 1'b0;
          end
        end
        HIGH: begin
          if (w_rise) begin
            r_high_cnt <= CNT_ONE;
            r_per_cnt  <= CNT_ONE;
            r_ovf      <= 1'b0;
          end else begin
            if (w_fall) begin
              r_state <= LOW;
            end else if (!w_high_sat) begin
              r_high_cnt <= r_high_cnt + CNT_ONE;
            end
            if (!w_per_sat) begin
              r_per_cnt <= r_per_cnt + CNT_ONE;
            end
            r_ovf <= r_ovf | w_per_sat | (w_high_sat & ~w_fall);
          end
        end
        LOW: begin
          if (w_rise) begin
            r_state    <= HIGH;
            r_high_cnt <= CNT_ONE;
            r_per_cnt  <= CNT_ONE;
            r_ovf      <= 1'b0;
          end else begin
            if (!w_per_sat) begin
              r_per_cnt <= r_per_cnt + CNT_ONE;
            end
            r_ovf <= r_ovf | w_per_sat;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result holding register: load on capture when empty or being drained, else drop and flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_res_high <= '0;
      r_res_per  <= '0;
      r_res_ovf  <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_dropped <= w_cap & r_valid & ~res_ready;
      if (w_cap && (!r_valid || res_ready)) begin
        r_valid    <= 1'b1;
        r_res_high <= w_cap_high;
        r_res_per  <= r_per_cnt;
        r_res_ovf  <= r_ovf;
      end else if (r_valid && res_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign res_valid  = r_valid;
  assign res_high   = r_res_high;
  assign res_period = r_res_per;
  assign res_ovf    = r_res_ovf;
  assign dropped    = r_dropped;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: W=8 and W=4 instances share stimulus and are checked every cycle
// against a reference built from detected-edge timestamps, plus table vectors and corner sequences.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pwm_in;
  logic       res_ready;
  logic       v8, d8, o8, v4, d4, o4;
  logic [7:0] h8, p8;
  logic [3:0] h4, p4;

  always #5 clk = ~clk;

  pwm_capture #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in), .res_ready(res_ready),
    .res_valid(v8), .res_high(h8), .res_period(p8), .res_ovf(o8), .dropped(d8)
  );

  pwm_capture #(.W(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in), .res_ready(res_ready),
    .res_valid(v4), .res_high(h4), .res_period(p4), .res_ovf(o4), .dropped(d4)
  );

  int checks = 0;
  int failures = 0;
  int kcyc = 0;
  int pat_pos = 0;

  // reference model state, index 0 = W8, index 1 = W4
  int mx[2] = '{255, 15};
  bit hist[3];
  bit armed[2], inmeas[2];
  int lrise[2], lfall[2];
  bit ev[2], ed[2], eo[2];
  int eh[2], ep[2];
  int seen_valid[2], seen_drop[2];

  typedef struct {
    int hi; int lo;
    int h8; int p8; int o8;
    int h4; int p4; int o4;
  } vec_t;
  vec_t tbl[7];

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, kcyc);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < 3; j++) hist[j] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      armed[i] = 0; inmeas[i] = 0; lrise[i] = 0; lfall[i] = -1;
      ev[i] = 0; ed[i] = 0; eo[i] = 0; eh[i] = 0; ep[i] = 0;
    end
  endtask

  // One clock edge of the reference: edges of pwm_in are seen 3 edges after sampling;
  // results are timestamp differences clipped to the counter maximum.
  task automatic model_step();
    bit rs, fl, cap;
    int per, hi;
    kcyc++;
    if (reset) begin
      model_clear();
      return;
    end
    rs = hist[1] & ~hist[2];
    fl = ~hist[1] & hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = pwm_in;
    for (int i = 0; i < 2; i++) begin
      cap = 0; per = 0; hi = 0;
      if (!enable) begin
        armed[i] = 0; inmeas[i] = 0;
      end else if (!armed[i]) begin
        armed[i] = 1;
      end else if (rs) begin
        if (inmeas[i]) begin
          per = kcyc - lrise[i];
          hi  = (lfall[i] >= 0) ? (lfall[i] - lrise[i]) : per;
          cap = 1;
        end
        inmeas[i] = 1; lrise[i] = kcyc; lfall[i] = -1;
      end else if (fl && inmeas[i] && lfall[i] < 0) begin
        lfall[i] = kcyc;
      end
      ed[i] = cap && ev[i] && !res_ready;
      if (cap && (!ev[i] || res_ready)) begin
        ev[i] = 1; eh[i] = imin(hi, mx[i]); ep[i] = imin(per, mx[i]); eo[i] = (per > mx[i]);
      end else if (!cap && ev[i] && res_ready) begin
        ev[i] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid8", v8, ev[0]);  chk("dropped8", d8, ed[0]);
    chk("high8", h8, eh[0]);   chk("period8", p8, ep[0]);  chk("ovf8", o8, eo[0]);
    chk("valid4", v4, ev[1]);  chk("dropped4", d4, ed[1]);
    chk("high4", h4, eh[1]);   chk("period4", p4, ep[1]);  chk("ovf4", o4, eo[1]);
    if (v8) seen_valid[0]++;
    if (v4) seen_valid[1]++;
    if (d8) seen_drop[0]++;
    if (d4) seen_drop[1]++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run_pat(input int hi, input int lo, input int n, input bit rnd_rdy);
    for (int c = 0; c < n; c++) begin
      pwm_in = (pat_pos < hi);
      pat_pos = (pat_pos + 1) % (hi + lo);
      if (rnd_rdy) res_ready = 1'($urandom % 2);
      tick();
    end
  endtask

  // Park the block disabled with pwm low, then enable so the next pattern rise is seen in ARM.
  task automatic setup_run(input bit rdy);
    enable = 0; pwm_in = 0; res_ready = 1;
    repeat (4) tick();
    enable = 1; res_ready = rdy;
    tick();
    pat_pos = 0;
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 1;
    #1;
    chk({tag, "_valid8"}, v8, 0); chk({tag, "_high8"}, h8, 0); chk({tag, "_period8"}, p8, 0);
    chk({tag, "_ovf8"}, o8, 0);   chk({tag, "_drop8"}, d8, 0);
    chk({tag, "_valid4"}, v4, 0); chk({tag, "_high4"}, h4, 0); chk({tag, "_period4"}, p4, 0);
    chk({tag, "_ovf4"}, o4, 0);   chk({tag, "_drop4"}, d4, 0);
    model_clear();
    enable = 0; pwm_in = 0;
    repeat (2) tick();
    reset = 0;
    tick();
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int sv0, sv1, sd0, sd1, n;
    bit found;

    tbl[0] = '{5, 11, 5, 16, 0, 5, 15, 1};
    tbl[1] = '{20, 4, 20, 24, 0, 15, 15, 1};
    tbl[2] = '{3, 3, 3, 6, 0, 3, 6, 0};
    tbl[3] = '{1, 1, 1, 2, 0, 1, 2, 0};
    tbl[4] = '{7, 8, 7, 15, 0, 7, 15, 0};
    tbl[5] = '{8, 8, 8, 16, 0, 8, 15, 1};
    tbl[6] = '{100, 200, 100, 255, 1, 15, 15, 1};

    reset = 1; enable = 0; pwm_in = 0; res_ready = 1;
    model_clear();
    for (int i = 0; i < 2; i++) begin seen_valid[i] = 0; seen_drop[i] = 0; end
    repeat (2) tick();
    chk("reset_valid8", v8, 0); chk("reset_high8", h8, 0); chk("reset_period8", p8, 0);
    chk("reset_valid4", v4, 0); chk("reset_drop4", d4, 0);
    reset = 0;
    tick();

    // Table vectors: three periods, two captures, last captured fields held afterwards.
    for (int r = 0; r < 7; r++) begin
      setup_run(1'b1);
      sv0 = seen_valid[0]; sv1 = seen_valid[1];
      run_pat(tbl[r].hi, tbl[r].lo, 3 * (tbl[r].hi + tbl[r].lo), 1'b0);
      pwm_in = 0;
      repeat (6) tick();
      chk($sformatf("tbl%0d_caps8", r), seen_valid[0] - sv0, 2);
      chk($sformatf("tbl%0d_caps4", r), seen_valid[1] - sv1, 2);
      chk($sformatf("tbl%0d_high8", r), h8, tbl[r].h8);
      chk($sformatf("tbl%0d_period8", r), p8, tbl[r].p8);
      chk($sformatf("tbl%0d_ovf8", r), o8, tbl[r].o8);
      chk($sformatf("tbl%0d_high4", r), h4, tbl[r].h4);
      chk($sformatf("tbl%0d_period4", r), p4, tbl[r].p4);
      chk($sformatf("tbl%0d_ovf4", r), o4, tbl[r].o4);
    end

    // Backpressure: first result held, later captures dropped, then one accept.
    setup_run(1'b0);
    sd0 = seen_drop[0]; sd1 = seen_drop[1];
    run_pat(5, 11, 96, 1'b0);
    chk("bp_held_valid8", v8, 1); chk("bp_held_high8", h8, 5); chk("bp_held_period8", p8, 16);
    chk("bp_drops8", seen_drop[0] - sd0, 4);
    chk("bp_drops4", seen_drop[1] - sd1, 4);
    res_ready = 1;
    run_pat(5, 11, 1, 1'b0);
    chk("bp_accept_valid8", v8, 0);
    res_ready = 0;
    run_pat(5, 11, 16, 1'b0);
    chk("bp_next_valid8", v8, 1); chk("bp_next_high8", h8, 5); chk("bp_next_period8", p8, 16);
    chk("bp_next_valid4", v4, 1); chk("bp_next_ovf4", o4, 1);
    chk("bp_no_new_drop8", seen_drop[0] - sd0, 4);
    res_ready = 1;
    run_pat(5, 11, 20, 1'b0);

    // Constant low then constant high: no captures, no drops.
    setup_run(1'b0);
    sv0 = seen_valid[0]; sv1 = seen_valid[1]; sd0 = seen_drop[0]; sd1 = seen_drop[1];
    pwm_in = 0;
    repeat (1000) tick();
    pwm_in = 1;
    repeat (1000) tick();
    chk("const_valid8", seen_valid[0] - sv0, 0); chk("const_valid4", seen_valid[1] - sv1, 0);
    chk("const_drop8", seen_drop[0] - sd0, 0);   chk("const_drop4", seen_drop[1] - sd1, 0);
    pwm_in = 0; res_ready = 1;
    repeat (6) tick();

    // Enable dropped mid-HIGH, restored 10 cycles later: first result one period after the ARM rise.
    setup_run(1'b1);
    run_pat(5, 11, 37, 1'b0);
    enable = 0;
    run_pat(5, 11, 10, 1'b0);
    enable = 1;
    n = 0; found = 0;
    while (!found && n < 60) begin
      run_pat(5, 11, 1, 1'b0);
      n++;
      if (v8) found = 1;
    end
    chk("en_first_found", found, 1);
    chk("en_first_latency", n, 20);
    chk("en_first_high8", h8, 5); chk("en_first_period8", p8, 16);
    chk("en_first_valid4", v4, 1); chk("en_first_period4", p4, 15);

    // Reset with a pending result, then a fresh measurement.
    setup_run(1'b0);
    run_pat(5, 11, 36, 1'b0);
    chk("rst_pending_valid8", v8, 1);
    do_reset("arst");
    enable = 1; res_ready = 1; pat_pos = 0;
    n = 0; found = 0;
    while (!found && n < 60) begin
      run_pat(5, 11, 1, 1'b0);
      n++;
      if (v8) found = 1;
    end
    chk("rst_first_found", found, 1);
    chk("rst_first_latency", n, 19);
    chk("rst_first_high8", h8, 5); chk("rst_first_period8", p8, 16);

    // Random segments with random handshake, enable gaps and occasional reset.
    for (int s = 0; s < 40; s++) begin
      int hi, lo;
      hi = $urandom_range(1, 30);
      lo = $urandom_range(1, 30);
      if ($urandom_range(0, 5) == 0) begin
        enable = 0;
        run_pat(hi, lo, $urandom_range(1, 8), 1'b1);
        enable = 1;
      end
      if ($urandom_range(0, 14) == 0) do_reset("rnd_rst");
      enable = 1;
      run_pat(hi, lo, $urandom_range(1, 4) * (hi + lo), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter: W, default 8, width of the high-time and period counters and result fields (W >= 4).
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: enable  input  1  measurement enable, synchronous to clk.
REQ-005 Port: pwm_in  input  1  PWM waveform under measurement, asynchronous to clk.
REQ-006 Port: res_ready  input  1  consumer accepts the result when high together with res_valid.
REQ-007 Port: res_valid  output  1  result fields hold a complete, unconsumed measurement.
REQ-008 Port: res_high  output  W  clk cycles pwm_in was high in the measured period.
REQ-009 Port: res_period  output  W  clk cycles between consecutive rising edges of pwm_in.
REQ-010 Port: res_ovf  output  1  a counter saturated during the measured period.
REQ-011 Port: dropped  output  1  one-cycle pulse when a completed measurement is discarded.

Function
REQ-012 pwm_in SHALL pass through a 2-flop synchronizer, then a 1-flop edge detector; a rise/fall is detected 3 clk cycles after the pwm_in transition.
REQ-013 FSM states SHALL be IDLE, ARM, HIGH, LOW.
REQ-014 IDLE: go to ARM when enable=1; every state SHALL return to IDLE on the cycle enable=0, clearing both counters.
REQ-015 ARM: discard partial period; on first detected rise go to HIGH and start both counters.
REQ-016 HIGH: increment high and period counters each cycle; on detected fall go to LOW.
REQ-017 LOW: increment period counter only; on detected rise capture results, restart both counters, go to HIGH.
REQ-018 Captured res_period SHALL equal the cycle distance between the two detected rises; res_high SHALL equal the cycle distance from detected rise to detected fall.
REQ-019 Counters SHALL saturate at 2^W-1, never wrap; any saturation in a period SHALL set res_ovf for that capture.
REQ-020 Rise detected in HIGH (missed fall) SHALL be treated as a capture with res_high = res_period.
REQ-021 Capture SHALL load result fields and assert res_valid the following cycle (4 cycles after the pwm_in rise).
REQ-022 res_valid/fields SHALL hold stable until the cycle res_valid&res_ready=1; res_valid then deasserts next cycle unless a new capture occurs that same cycle, in which case the new result is loaded and res_valid stays high.
REQ-023 Capture while res_valid=1 and res_ready=0 SHALL discard the new result, keep the old one, and pulse dropped for one cycle.
REQ-024 Deasserting enable SHALL NOT clear a pending result; it remains valid until accepted.
REQ-025 Constant pwm_in (0% or 100% duty) SHALL produce no captures; counters saturate and hold.

Reset
REQ-026 While reset=1: FSM=IDLE, synchronizer/edge flops=0, counters=0, res_valid=0, res_high=0, res_period=0, res_ovf=0, dropped=0.
REQ-027 Reset asserted mid-measurement or with a pending result SHALL abandon both immediately; after release, first capture requires a fresh ARM rise plus one full period.

Verification
REQ-028 W=8, enable=1, res_ready=1, pwm_in 5 high/11 low repeating -> from 2nd rise onward res_valid pulses once per 16 cycles with res_high=5, res_period=16, res_ovf=0.
REQ-029 Same stimulus, res_ready=0 -> first result held (5,16), dropped pulses every 16 cycles; raise res_ready -> (5,16) accepted, next capture loaded.
REQ-030 W=4, pwm_in 20 high/4 low -> res_high=15, res_period=15, res_ovf=1.
REQ-031 pwm_in held 0 then held 1 for 1000 cycles -> res_valid never asserts, dropped never pulses.
REQ-032 Deassert enable mid-HIGH, reassert 10 cycles later, pwm 5/11 -> no partial result; first result (5,16) one full period after first rise seen in ARM.
REQ-033 Assert reset with res_valid=1 -> res_valid=0 and fields=0 asynchronously; normal operation resumes per REQ-027.
